// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the PIPE fetch/memory-stage memory arbiter.
//   arb_state_e : arbiter FSM states
//   sel_e       : requester select encoding (SEL_IF = fetch, SEL_DM = memory stage)
//   MEM_LIMIT_DEFAULT / STARVE_MAX_DEFAULT : default parameter values
package pipe_mem_pkg;

  localparam int unsigned MEM_LIMIT_DEFAULT  = 1023;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    ERR_IF  = 3'd3,
    ERR_DM  = 3'd4
  } arb_state_e;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_DM = 1'b1
  } sel_e;

endpackage

// File: rtl/pipe_arb_starve_ctr.sv
// Saturating count of memory-stage grants issued while fetch was waiting.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : a memory-stage grant was issued while fetch requested
//   clr        : a fetch grant was issued (clear wins over inc)
//   at_max_c   : count has reached MAX (combinational from the count register)
module pipe_arb_starve_ctr
  import pipe_mem_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max_c
);

  localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  logic [CNT_W-1:0] count;

  // Saturating counter; a fetch grant resets the fairness window.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_max_c = (count == CNT_MAX);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch stage (reads) and the
// memory stage (reads/writes) using a req/gnt/done handshake toward the stages
// and an en/ready handshake toward a variable-latency memory. Addresses above
// MEM_LIMIT complete with an error and never reach the memory.
// Optional feature macro: PIPE_ARB_STARVE_GUARD_EN -- after STARVE_MAX
// consecutive memory-stage grants with fetch waiting, fetch wins once.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   if_req/if_addr                     : fetch read request (held until if_gnt)
//   if_gnt/if_done/if_rdata/if_err     : fetch grant pulse, completion pulse, data, error
//   dm_req/dm_we/dm_addr/dm_wdata      : memory-stage request (held until dm_gnt)
//   dm_gnt/dm_done/dm_rdata/dm_err     : memory-stage grant, completion, data, error
//   mem_en/mem_we/mem_addr/mem_wdata   : memory access start pulse and latched command
//   mem_rdata/mem_ready                : memory read data and completion
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
`ifdef PIPE_ARB_STARVE_GUARD_EN
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
`endif
  parameter int unsigned MEM_LIMIT  = MEM_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(MEM_LIMIT);

  arb_state_e        state, state_d;
  sel_e              sel_c;
  logic              starve_force_c;
  logic              addr_ok_c;
  logic [DATA_W-1:0] req_addr_c;
  logic              if_grant_c, dm_grant_c;

  logic              if_gnt_d, if_done_d, if_err_d;
  logic              dm_gnt_d, dm_done_d, dm_err_d;
  logic              mem_en_d, mem_we_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d, mem_addr_d, mem_wdata_d;

`ifdef PIPE_ARB_STARVE_GUARD_EN
  // Fairness guard: counts dm grants that overtook a waiting fetch.
  pipe_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (dm_grant_c & if_req),
    .clr      (if_grant_c),
    .at_max_c (starve_force_c)
  );
`else
  assign starve_force_c = 1'b0;
`endif

  // Memory stage has priority unless the starvation guard forces fetch.
  assign sel_c      = (dm_req && !(if_req && starve_force_c)) ? SEL_DM : SEL_IF;
  assign req_addr_c = (sel_c == SEL_DM) ? dm_addr : if_addr;
  assign addr_ok_c  = (req_addr_c <= LIMIT);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    if_grant_c  = 1'b0;
    dm_grant_c  = 1'b0;
    if_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = '0;
    dm_gnt_d    = 1'b0;
    dm_done_d   = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_en_d = addr_ok_c;
          if (sel_c == SEL_DM) begin
            dm_grant_c  = 1'b1;
            dm_gnt_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            state_d     = addr_ok_c ? BUSY_DM : ERR_DM;
          end else begin
            if_grant_c  = 1'b1;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            state_d     = addr_ok_c ? BUSY_IF : ERR_IF;
          end
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = IDLE;
        end
      end
      BUSY_DM: begin
        if (mem_ready) begin
          dm_done_d  = 1'b1;
          dm_rdata_d = mem_we ? '0 : mem_rdata;
          state_d    = IDLE;
        end
      end
      ERR_IF: begin
        if_done_d = 1'b1;
        if_err_d  = 1'b1;
        state_d   = IDLE;
      end
      ERR_DM: begin
        dm_done_d = 1'b1;
        dm_err_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= if_gnt_d;
      if_done   <= if_done_d;
      if_err    <= if_err_d;
      if_rdata  <= if_rdata_d;
      dm_gnt    <= dm_gnt_d;
      dm_done   <= dm_done_d;
      dm_err    <= dm_err_d;
      dm_rdata  <= dm_rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: requesters push expected responses
// from a reference memory image; a negedge monitor pops and compares on done.
module tb_pipe_mem_arbiter;

  localparam logic [63:0] LIMIT = 64'd1023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_gnt, if_done, if_err;
  logic [63:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [63:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic        dm_gnt, dm_done, dm_err;
  logic [63:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  pipe_mem_arbiter #(
    .DATA_W    (64),
    .MEM_LIMIT (1023)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_if[$];
  exp_t        exp_dm[$];
  logic [63:0] ref_mem   [logic [63:0]];
  logic [63:0] mem_store [logic [63:0]];

  int n_cmp = 0;
  int n_fail = 0;

  int if_gnt_cyc = -1, if_done_cyc = -1, dm_gnt_cyc = -1, dm_done_cyc = -1;
  int mem_en_cyc = -1, mem_en_cnt = 0, dm_done_cnt = 0;
  logic        en_we;
  logic [63:0] en_addr, en_wdata;
  string       gnt_str = "";

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h5A5A_0000_0000_A5A5;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: protocol checks and scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (if_gnt || dm_gnt) begin
      check("gnt_exclusive", 64'(if_gnt & dm_gnt), 64'd0);
      if (if_gnt) begin gnt_str = {gnt_str, "I"}; if_gnt_cyc = cyc; end
      if (dm_gnt) begin gnt_str = {gnt_str, "D"}; dm_gnt_cyc = cyc; end
    end
    if (mem_en) begin
      mem_en_cnt++;
      mem_en_cyc = cyc;
      en_we    = mem_we;
      en_addr  = mem_addr;
      en_wdata = mem_wdata;
      check("mem_addr_range", 64'(mem_addr > LIMIT), 64'd0);
      check("mem_en_with_gnt", 64'(if_gnt | dm_gnt), 64'd1);
    end
    if (if_done) begin
      if_done_cyc = cyc;
      if (exp_if.size() == 0) fail_now("if_done_unexpected");
      else begin
        e = exp_if.pop_front();
        check("if_rdata", if_rdata, e.rdata);
        check("if_err", 64'(if_err), 64'(e.err));
      end
    end else begin
      check("if_idle_zero", if_rdata | 64'(if_err), 64'd0);
    end
    if (dm_done) begin
      dm_done_cyc = cyc;
      dm_done_cnt++;
      if (exp_dm.size() == 0) fail_now("dm_done_unexpected");
      else begin
        e = exp_dm.pop_front();
        check("dm_rdata", dm_rdata, e.rdata);
        check("dm_err", 64'(dm_err), 64'(e.err));
      end
    end else begin
      check("dm_idle_zero", dm_rdata | 64'(dm_err), 64'd0);
    end
  end

  // Memory responder: fixed or random latency, optional spurious ready.
  int          lat_fixed = 0;
  bit          resp_en = 1'b1;
  bit          spur_en = 1'b0;
  logic        manual_ready = 1'b0;
  bit          r_busy = 1'b0;
  int          r_lat = 0;
  logic        r_we = 1'b0;
  logic [63:0] r_addr = '0, r_wdata = '0;

  always begin
    @(negedge clk);
    #1;
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (!resp_en) begin
      mem_ready = manual_ready;
    end else begin
      if (mem_en) begin
        r_busy  = 1'b1;
        r_we    = mem_we;
        r_addr  = mem_addr;
        r_wdata = mem_wdata;
        r_lat   = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end
      if (r_busy) begin
        if (r_lat == 0) begin
          mem_ready = 1'b1;
          r_busy    = 1'b0;
          if (r_we) mem_store[r_addr] = r_wdata;
          else mem_rdata = mem_read(r_addr);
        end else begin
          r_lat--;
        end
      end else if (spur_en && !mem_en && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1;
      end
    end
  end

  task automatic if_issue(input logic [63:0] a, input bit push);
    exp_t e;
    int   n;
    if (push) begin
      e.err   = (a > LIMIT);
      e.rdata = e.err ? 64'd0 : ref_read(a);
      exp_if.push_back(e);
    end
    if_addr = a;
    if_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt && n < 1000);
    if (!if_gnt) fail_now("if_gnt_timeout");
    if_req  = 1'b0;
    if_addr = '0;
  endtask

  task automatic dm_issue(input logic we, input logic [63:0] a, input logic [63:0] d, input bit push);
    exp_t e;
    int   n;
    if (push) begin
      e.err   = (a > LIMIT);
      e.rdata = (e.err || we) ? 64'd0 : ref_read(a);
      if (we && !e.err) ref_mem[a] = d;
      exp_dm.push_back(e);
    end
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
    dm_req   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_gnt && n < 1000);
    if (!dm_gnt) fail_now("dm_gnt_timeout");
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_if.size() != 0 || exp_dm.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] pick_if_addr();
    case ($urandom_range(0, 9))
      0: return 64'd1023;
      1: return 64'd1024;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0010;
      default: return 64'($urandom_range(0, 511));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int    c0;
    int    en_before;
    int    done_before;
    string exp_str;

    mem_store[64'd16] = 64'h30F3;
    ref_mem[64'd16]   = 64'h30F3;

    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err, mem_en, mem_we}), 64'd0);
    check("reset_bus", if_rdata | dm_rdata | mem_addr | mem_wdata, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait fetch read.
    lat_fixed = 0;
    c0 = cyc;
    if_issue(64'd16, 1'b1);
    drain();
    check("t1_if_gnt_cyc", 64'(if_gnt_cyc), 64'(c0 + 1));
    check("t1_mem_en_cyc", 64'(mem_en_cyc), 64'(c0 + 1));
    check("t1_if_done_cyc", 64'(if_done_cyc), 64'(c0 + 2));

    // Data write with 3-cycle memory latency.
    lat_fixed = 3;
    dm_issue(1'b1, 64'd200, 64'hAB, 1'b1);
    drain();
    check("t2_mem_we", 64'(en_we), 64'd1);
    check("t2_mem_addr", en_addr, 64'd200);
    check("t2_mem_wdata", en_wdata, 64'hAB);
    check("t2_done_lat", 64'(dm_done_cyc - dm_gnt_cyc), 64'd4);

    // Simultaneous requests: memory stage first, fetch on the done cycle.
    lat_fixed = 0;
    c0 = cyc;
    fork
      if_issue(64'd24, 1'b1);
      dm_issue(1'b0, 64'd40, 64'd0, 1'b1);
    join
    drain();
    check("t3_dm_gnt_cyc", 64'(dm_gnt_cyc), 64'(c0 + 1));
    check("t3_dm_done_cyc", 64'(dm_done_cyc), 64'(c0 + 2));
    check("t3_if_gnt_cyc", 64'(if_gnt_cyc), 64'(c0 + 3));
    check("t3_if_done_cyc", 64'(if_done_cyc), 64'(c0 + 4));

    // Out-of-range data read.
    en_before = mem_en_cnt;
    c0 = cyc;
    dm_issue(1'b0, 64'd1024, 64'd0, 1'b1);
    drain();
    check("t4_dm_gnt_cyc", 64'(dm_gnt_cyc), 64'(c0 + 1));
    check("t4_dm_done_cyc", 64'(dm_done_cyc), 64'(c0 + 2));
    check("t4_no_mem_en", 64'(mem_en_cnt), 64'(en_before));

    // Reset while BUSY_DM, then a late mem_ready.
    resp_en = 1'b0;
    manual_ready = 1'b0;
    done_before = dm_done_cnt;
    dm_issue(1'b0, 64'd300, 64'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    manual_ready = 1'b1;
    check("t5_rst_ctrl", 64'({if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err, mem_en, mem_we}), 64'd0);
    check("t5_rst_bus", if_rdata | dm_rdata | mem_addr | mem_wdata, 64'd0);
    @(negedge clk);
    manual_ready = 1'b0;
    check("t5_late_ready_ctrl", 64'({if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err, mem_en, mem_we}), 64'd0);
    repeat (3) @(negedge clk);
    check("t5_no_dm_done", 64'(dm_done_cnt), 64'(done_before));
    resp_en = 1'b1;
    c0 = cyc;
    if_issue(64'd64, 1'b1);
    drain();
    check("t5_idle_gnt_cyc", 64'(if_gnt_cyc), 64'(c0 + 1));

    // Fetch held while the memory stage issues back-to-back.
    lat_fixed = -1;
    gnt_str = "";
    fork
      if_issue(64'd8, 1'b1);
      begin
        for (int i = 0; i < 6; i++) dm_issue(1'b1, 64'(600 + i), {$urandom, $urandom}, 1'b1);
      end
    join
    drain();
`ifdef PIPE_ARB_STARVE_GUARD_EN
    exp_str = "DDDDIDD";
`else
    exp_str = "DDDDDDI";
`endif
    n_cmp++;
    if (gnt_str != exp_str) begin
      n_fail++;
      $display("FAIL t6_grant_order: got %s expected %s", gnt_str, exp_str);
    end

    // Randomized traffic with spurious/back-to-back mem_ready.
    spur_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          if_issue(pick_if_addr(), 1'b1);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          logic        we;
          logic [63:0] a;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          we = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) a = 64'h0000_0001_0000_0000;
          else if (we) a = 64'(512 + $urandom_range(0, 510));
          else a = 64'($urandom_range(0, 1023));
          dm_issue(we, a, {$urandom, $urandom}, 1'b1);
        end
      end
    join
    drain();
    check("scoreboard_empty", 64'(exp_if.size() + exp_dm.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
